// File: rtl/tictactoe_engine.sv
// N x N, K-in-a-row game engine: holds the board, enforces turn order,
// rejects illegal moves with a cause code and reports win/draw status.
module tictactoe_engine #(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int PW = $clog2(N*N)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       new_game,
    input  logic                       move_valid,
    input  logic                       player,
    input  logic [PW-1:0]              position,
    output logic                       move_ready,
    output logic                       move_ack,
    output logic                       move_err,
    output logic [1:0]                 err_code,
    output logic [N*N-1:0]             cell_occ,
    output logic [N*N-1:0]             cell_owner,
    output logic                       turn,
    output logic [$clog2(N*N+1)-1:0]   move_count,
    output logic                       game_over,
    output logic [1:0]                 winner,
    output logic [1:0]                 fsm_state
);
    // Handshake: a request is move_valid high at a rising edge; exactly one of
    // move_ack / move_err pulses on the following edge. move_ready only hints PLAY.
    localparam int CELLS = N * N;
    localparam int CW    = $clog2(N*N+1);
    localparam int SPAN  = N - K + 1;
    localparam logic [CW-1:0] FULL = CW'(CELLS);

    localparam logic [1:0] ST_PLAY  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic             last_player;
    logic [CELLS-1:0] pos_onehot;
    logic [CELLS-1:0] owned;
    logic [4*CELLS-1:0] hits;
    logic             in_range;
    logic             occupied;
    logic             win_hit;

    assign fsm_state  = state;
    assign move_ready = (state == ST_PLAY);
    assign in_range   = 32'(position) < 32'(CELLS);
    assign pos_onehot = {{(CELLS-1){1'b0}}, 1'b1} << position;
    assign occupied   = |(cell_occ & pos_onehot);
    assign owned      = last_player ? (cell_occ & cell_owner) : (cell_occ & ~cell_owner);
    assign win_hit    = |hits;

    // One hit bit per (direction, start cell); directions: 0 row, 1 column,
    // 2 diagonal, 3 anti-diagonal. Starts that would leave the board tie to 0.
    for (genvar d = 0; d < 4; d++) begin : g_dir
        localparam int DR = (d == 0) ? 0 : 1;
        localparam int DC = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
        for (genvar r = 0; r < N; r++) begin : g_row
            for (genvar c = 0; c < N; c++) begin : g_col
                localparam bit FITS = (d == 0) ? (c < SPAN) :
                                      (d == 1) ? (r < SPAN) :
                                      (d == 2) ? (r < SPAN && c < SPAN) :
                                                 (r < SPAN && c >= K - 1);
                if (FITS) begin : g_win
                    logic [K-1:0] line;
                    for (genvar k = 0; k < K; k++) begin : g_cell
                        assign line[k] = owned[(r + DR*k)*N + (c + DC*k)];
                    end
                    assign hits[d*CELLS + r*N + c] = &line;
                end else begin : g_none
                    assign hits[d*CELLS + r*N + c] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_PLAY;
            cell_occ    <= '0;
            cell_owner  <= '0;
            move_count  <= '0;
            turn        <= 1'b0;
            last_player <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 2'b00;
            move_ack    <= 1'b0;
            move_err    <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            move_ack <= 1'b0;
            move_err <= 1'b0;
            if (new_game) begin
                state       <= ST_PLAY;
                cell_occ    <= '0;
                cell_owner  <= '0;
                move_count  <= '0;
                turn        <= 1'b0;
                last_player <= 1'b0;
                game_over   <= 1'b0;
                winner      <= 2'b00;
                err_code    <= 2'b00;
            end else begin
                case (state)
                    ST_PLAY: begin
                        if (move_valid) begin
                            if (!in_range) begin
                                move_err <= 1'b1;
                                err_code <= 2'b01;
                            end else if (player != turn) begin
                                move_err <= 1'b1;
                                err_code <= 2'b10;
                            end else if (occupied) begin
                                move_err <= 1'b1;
                                err_code <= 2'b11;
                            end else begin
                                move_ack    <= 1'b1;
                                cell_occ    <= cell_occ | pos_onehot;
                                cell_owner  <= player ? (cell_owner | pos_onehot) : cell_owner;
                                move_count  <= move_count + CW'(1);
                                turn        <= ~turn;
                                last_player <= player;
                                state       <= ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (move_valid) begin
                            move_err <= 1'b1;
                            err_code <= 2'b00;
                        end
                        // A win on the last free cell takes precedence over a draw.
                        if (win_hit) begin
                            winner    <= {last_player, ~last_player};
                            game_over <= 1'b1;
                            state     <= ST_DONE;
                        end else if (move_count == FULL) begin
                            winner    <= 2'b11;
                            game_over <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_PLAY;
                        end
                    end
                    default: begin
                        if (move_valid) begin
                            move_err <= 1'b1;
                            err_code <= 2'b00;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tictactoe_engine.sv
// Directed bench for tictactoe_engine: a 3x3/K=3 instance and a 5x5/K=4 instance
// share clock and reset; each scenario task checks its own expected values.
module tb_tictactoe_engine;
    logic        clk;
    logic        reset;
    int          n_cmp;
    int          n_fail;

    logic        ng3, mv3, pl3;
    logic [3:0]  pos3;
    logic        ready3, ack3, err3, turn3, over3;
    logic [1:0]  code3, win3, st3;
    logic [8:0]  occ3, own3;
    logic [3:0]  cnt3;

    logic        ng5, mv5, pl5;
    logic [4:0]  pos5;
    logic        ready5, ack5, err5, turn5, over5;
    logic [1:0]  code5, win5, st5;
    logic [24:0] occ5, own5;
    logic [4:0]  cnt5;

    tictactoe_engine #(.N(3), .K(3)) u3 (
        .clk(clk), .reset(reset), .new_game(ng3), .move_valid(mv3), .player(pl3),
        .position(pos3), .move_ready(ready3), .move_ack(ack3), .move_err(err3),
        .err_code(code3), .cell_occ(occ3), .cell_owner(own3), .turn(turn3),
        .move_count(cnt3), .game_over(over3), .winner(win3), .fsm_state(st3)
    );

    tictactoe_engine #(.N(5), .K(4)) u5 (
        .clk(clk), .reset(reset), .new_game(ng5), .move_valid(mv5), .player(pl5),
        .position(pos5), .move_ready(ready5), .move_ack(ack5), .move_err(err5),
        .err_code(code5), .cell_occ(occ5), .cell_owner(own5), .turn(turn5),
        .move_count(cnt5), .game_over(over5), .winner(win5), .fsm_state(st5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one request; returns 1 time unit after the sampling edge, so the
    // ack/err pulse for this request is visible to the caller.
    task automatic move3(input logic p, input logic [3:0] pos, input bit wait_rdy);
        int w;
        @(negedge clk);
        w = 0;
        while (wait_rdy && !ready3 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (wait_rdy && !ready3) begin
            n_cmp++; n_fail++;
            $display("FAIL move3_ready_timeout: got ready=%b want 1", ready3);
        end
        mv3 = 1'b1; pl3 = p; pos3 = pos;
        @(posedge clk); #1;
        mv3 = 1'b0;
    endtask

    task automatic move5(input logic p, input logic [4:0] pos);
        int w;
        @(negedge clk);
        w = 0;
        while (!ready5 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!ready5) begin
            n_cmp++; n_fail++;
            $display("FAIL move5_ready_timeout: got ready=%b want 1", ready5);
        end
        mv5 = 1'b1; pl5 = p; pos5 = pos;
        @(posedge clk); #1;
        mv5 = 1'b0;
    endtask

    task automatic new_game3();
        @(negedge clk); ng3 = 1'b1;
        @(posedge clk); #1; ng3 = 1'b0;
    endtask

    task automatic new_game5();
        @(negedge clk); ng5 = 1'b1;
        @(posedge clk); #1; ng5 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_cmp++; if (ready3 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready3); end
        n_cmp++; if ({ack3, err3, code3} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 0000", {ack3, err3, code3}); end
        n_cmp++; if ({occ3, own3} !== 18'b0) begin n_fail++; $display("FAIL reset_board: got %h want 0", {occ3, own3}); end
        n_cmp++; if ({turn3, cnt3, over3, win3} !== 8'b0) begin n_fail++; $display("FAIL reset_status: got %b want 00000000", {turn3, cnt3, over3, win3}); end
        n_cmp++; if ({ready5, occ5, cnt5, win5} !== {1'b1, 32'b0}) begin n_fail++; $display("FAIL reset_n5: got %h want 100000000", {ready5, occ5, cnt5, win5}); end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_win3();
        logic [3:0] seq [5];
        seq = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd2};
        for (int i = 0; i < 5; i++) begin
            move3(i[0], seq[i], 1'b1);
            n_cmp++; if ({ack3, err3} !== 2'b10) begin n_fail++; $display("FAIL win3_ack%0d: got ack/err=%b want 10", i, {ack3, err3}); end
        end
        n_cmp++; if ({ready3, over3, win3} !== 4'b0000) begin n_fail++; $display("FAIL win3_check_cycle: got ready/over/win=%b want 0000", {ready3, over3, win3}); end
        @(posedge clk); #1;
        n_cmp++; if ({over3, win3} !== 3'b101) begin n_fail++; $display("FAIL win3_status: got over/win=%b want 101", {over3, win3}); end
        n_cmp++; if (occ3 !== 9'b000011111) begin n_fail++; $display("FAIL win3_occ: got %b want 000011111", occ3); end
        n_cmp++; if (own3 !== 9'b000011000) begin n_fail++; $display("FAIL win3_owner: got %b want 000011000", own3); end
        n_cmp++; if ({cnt3, turn3} !== 5'b01011) begin n_fail++; $display("FAIL win3_count_turn: got %b want 01011", {cnt3, turn3}); end
        new_game3();
        n_cmp++; if ({ready3, occ3, own3, cnt3, turn3, over3, win3, code3} !== {1'b1, 28'b0}) begin n_fail++; $display("FAIL newgame_done_clear: got %h want 10000000", {ready3, occ3, own3, cnt3, turn3, over3, win3, code3}); end
    endtask

    task automatic test_p2_win3();
        logic [3:0] seq [6];
        seq = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd8, 4'd5};
        for (int i = 0; i < 6; i++) move3(i[0], seq[i], 1'b1);
        @(posedge clk); #1;
        n_cmp++; if ({over3, win3} !== 3'b110) begin n_fail++; $display("FAIL p2win_status: got over/win=%b want 110", {over3, win3}); end
        n_cmp++; if (own3 !== 9'b000111000) begin n_fail++; $display("FAIL p2win_owner: got %b want 000111000", own3); end
        new_game3();
    endtask

    task automatic test_illegal3();
        move3(1'b1, 4'd0, 1'b1);
        n_cmp++; if ({ack3, err3, code3} !== 4'b0110) begin n_fail++; $display("FAIL ill_turn: got ack/err/code=%b want 0110", {ack3, err3, code3}); end
        move3(1'b0, 4'd9, 1'b1);
        n_cmp++; if ({ack3, err3, code3} !== 4'b0101) begin n_fail++; $display("FAIL ill_range9: got ack/err/code=%b want 0101", {ack3, err3, code3}); end
        move3(1'b1, 4'd15, 1'b1);
        n_cmp++; if ({err3, code3} !== 3'b101) begin n_fail++; $display("FAIL ill_range15_prio: got err/code=%b want 101", {err3, code3}); end
        n_cmp++; if ({occ3, cnt3, ready3} !== 14'b1) begin n_fail++; $display("FAIL ill_unchanged0: got %b want 1", {occ3, cnt3, ready3}); end
        move3(1'b0, 4'd4, 1'b1);
        n_cmp++; if ({ack3, err3} !== 2'b10) begin n_fail++; $display("FAIL ill_legal4: got ack/err=%b want 10", {ack3, err3}); end
        move3(1'b1, 4'd4, 1'b1);
        n_cmp++; if ({ack3, err3, code3} !== 4'b0111) begin n_fail++; $display("FAIL ill_occupied: got ack/err/code=%b want 0111", {ack3, err3, code3}); end
        move3(1'b0, 4'd4, 1'b1);
        n_cmp++; if ({err3, code3} !== 3'b110) begin n_fail++; $display("FAIL ill_turn_over_occ: got err/code=%b want 110", {err3, code3}); end
        n_cmp++; if ({occ3, own3, cnt3} !== {9'h010, 9'h000, 4'd1}) begin n_fail++; $display("FAIL ill_unchanged1: got %h want %h", {occ3, own3, cnt3}, {9'h010, 9'h000, 4'd1}); end
        new_game3();
        n_cmp++; if ({code3, occ3, cnt3} !== 15'b0) begin n_fail++; $display("FAIL ill_newgame_clear: got %h want 0", {code3, occ3, cnt3}); end
    endtask

    task automatic test_draw3();
        logic [3:0] seq [9];
        seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
        for (int i = 0; i < 9; i++) begin
            move3(i[0], seq[i], 1'b1);
            n_cmp++; if (ack3 !== 1'b1) begin n_fail++; $display("FAIL draw_ack%0d: got %b want 1", i, ack3); end
        end
        @(posedge clk); #1;
        n_cmp++; if ({cnt3, over3, win3} !== {4'd9, 3'b111}) begin n_fail++; $display("FAIL draw_status: got cnt/over/win=%b want 1001111", {cnt3, over3, win3}); end
        n_cmp++; if ({occ3, own3} !== {9'h1FF, 9'h072}) begin n_fail++; $display("FAIL draw_board: got %h want %h", {occ3, own3}, {9'h1FF, 9'h072}); end
        move3(1'b1, 4'd0, 1'b0);
        n_cmp++; if ({ack3, err3, code3} !== 4'b0100) begin n_fail++; $display("FAIL done_busy_err: got ack/err/code=%b want 0100", {ack3, err3, code3}); end
        n_cmp++; if ({ready3, cnt3, win3} !== {1'b0, 4'd9, 2'b11}) begin n_fail++; $display("FAIL done_hold: got %b want 0100111", {ready3, cnt3, win3}); end
        new_game3();
    endtask

    task automatic test_final_cell_win3();
        logic [3:0] seq [9];
        seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd4, 4'd7, 4'd6, 4'd8};
        for (int i = 0; i < 9; i++) move3(i[0], seq[i], 1'b1);
        @(posedge clk); #1;
        n_cmp++; if ({cnt3, over3, win3} !== {4'd9, 3'b101}) begin n_fail++; $display("FAIL final_cell_win: got cnt/over/win=%b want 1001101", {cnt3, over3, win3}); end
        new_game3();
    endtask

    task automatic test_busy_in_check3();
        move3(1'b0, 4'd0, 1'b1);
        move3(1'b1, 4'd1, 1'b0);
        n_cmp++; if ({ack3, err3, code3} !== 4'b0100) begin n_fail++; $display("FAIL check_busy_err: got ack/err/code=%b want 0100", {ack3, err3, code3}); end
        n_cmp++; if ({occ3, cnt3, turn3} !== {9'h001, 4'd1, 1'b1}) begin n_fail++; $display("FAIL check_busy_nochange: got %h want %h", {occ3, cnt3, turn3}, {9'h001, 4'd1, 1'b1}); end
        new_game3();
    endtask

    task automatic test_n5();
        logic [4:0] seq [7];
        seq = '{5'd4, 5'd0, 5'd8, 5'd1, 5'd12, 5'd2, 5'd16};
        for (int i = 0; i < 7; i++) begin
            move5(i[0], seq[i]);
            n_cmp++; if (ack5 !== 1'b1) begin n_fail++; $display("FAIL n5_anti_ack%0d: got %b want 1", i, ack5); end
            if (i == 5) begin
                @(posedge clk); #1;
                n_cmp++; if ({over5, win5} !== 3'b000) begin n_fail++; $display("FAIL n5_no_early_win: got over/win=%b want 000", {over5, win5}); end
            end
        end
        @(posedge clk); #1;
        n_cmp++; if ({cnt5, over5, win5} !== {5'd7, 3'b101}) begin n_fail++; $display("FAIL n5_anti_win: got cnt/over/win=%b want 00111101", {cnt5, over5, win5}); end
        new_game5();
        seq = '{5'd5, 5'd0, 5'd6, 5'd1, 5'd7, 5'd2, 5'd8};
        for (int i = 0; i < 7; i++) move5(i[0], seq[i]);
        @(posedge clk); #1;
        n_cmp++; if ({over5, win5} !== 3'b101) begin n_fail++; $display("FAIL n5_row_win: got over/win=%b want 101", {over5, win5}); end
        n_cmp++; if (occ5 !== 25'h0001E7) begin n_fail++; $display("FAIL n5_row_occ: got %h want 0001e7", occ5); end
        new_game5();
    endtask

    task automatic test_reset_in_check();
        logic [3:0] seq [5];
        seq = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd2};
        for (int i = 0; i < 5; i++) move3(i[0], seq[i], 1'b1);
        n_cmp++; if (st3 !== 2'd1) begin n_fail++; $display("FAIL rst_chk_in_check: got state=%0d want 1", st3); end
        reset = 1'b0;
        #1;
        n_cmp++; if ({occ3, cnt3, ack3} !== 14'b0) begin n_fail++; $display("FAIL rst_chk_async: got %h want 0", {occ3, cnt3, ack3}); end
        @(posedge clk); #1;
        n_cmp++; if ({over3, win3, occ3, own3, ready3} !== {21'b0, 1'b1}) begin n_fail++; $display("FAIL rst_chk_no_leak: got %h want 1", {over3, win3, occ3, own3, ready3}); end
        @(negedge clk); reset = 1'b1;
        move3(1'b0, 4'd4, 1'b1);
        n_cmp++; if ({ack3, occ3} !== {1'b1, 9'h010}) begin n_fail++; $display("FAIL rst_chk_resume: got %h want %h", {ack3, occ3}, {1'b1, 9'h010}); end
        @(posedge clk); #1;
        n_cmp++; if ({cnt3, turn3, over3, ready3} !== {4'd1, 1'b1, 1'b0, 1'b1}) begin n_fail++; $display("FAIL rst_chk_resume_status: got %b want 0001101", {cnt3, turn3, over3, ready3}); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        ng3 = 1'b0; mv3 = 1'b0; pl3 = 1'b0; pos3 = '0;
        ng5 = 1'b0; mv5 = 1'b0; pl5 = 1'b0; pos5 = '0;
        test_reset();
        test_win3();
        test_p2_win3();
        test_illegal3();
        test_draw3();
        test_final_cell_win3();
        test_busy_in_check3();
        test_n5();
        test_reset_in_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
